// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port mem RAM between instruction fetch (port 0)
// and load/store (port 1). One transaction is in flight at a time; all memory
// drive and responses are registered, only reqx_ready_o is combinational.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; when it is
// undefined, port 1 (load/store) wins every tie and no pointer register exists.
module mem_arbiter #(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int MEM_RD_LAT       = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               req0_valid_i,
    output logic                               req0_ready_o,
    input  logic                               req0_we_i,
    input  logic [ADDR_WIDTH-1:0]              req0_addr_i,
    input  logic [DATA_WIDTH_BYTES-1:0]        req0_be_i,
    input  logic [8*DATA_WIDTH_BYTES-1:0]      req0_wdata_i,
    output logic                               rsp0_valid_o,
    output logic [8*DATA_WIDTH_BYTES-1:0]      rsp0_rdata_o,
    input  logic                               req1_valid_i,
    output logic                               req1_ready_o,
    input  logic                               req1_we_i,
    input  logic [ADDR_WIDTH-1:0]              req1_addr_i,
    input  logic [DATA_WIDTH_BYTES-1:0]        req1_be_i,
    input  logic [8*DATA_WIDTH_BYTES-1:0]      req1_wdata_i,
    output logic                               rsp1_valid_o,
    output logic [8*DATA_WIDTH_BYTES-1:0]      rsp1_rdata_o,
    output logic [DATA_WIDTH_BYTES-1:0]        mem_wenableL_o,
    output logic [ADDR_WIDTH-1:0]              mem_addr_o,
    output logic [DATA_WIDTH_BYTES-1:0][7:0]   mem_w_o,
    input  logic [DATA_WIDTH_BYTES-1:0][7:0]   mem_r_i
);

    localparam int DW = 8 * DATA_WIDTH_BYTES;
    localparam int CW = (MEM_RD_LAT < 1) ? 1 : $clog2(MEM_RD_LAT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MEM_RD_LAT);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e state_q, state_d;
    logic owner_q, owner_d;
    logic we_q, we_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The memory drive registers double as the captured address, byte enables
    // and write data of the accepted request, so no separate payload copy is kept.
    logic [DATA_WIDTH_BYTES-1:0] memWenableL_q, memWenableL_d;
    logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
    logic [DW-1:0] memW_q, memW_d;

    logic rsp0Valid_q, rsp0Valid_d;
    logic rsp1Valid_q, rsp1Valid_d;
    logic [DW-1:0] rsp0Rdata_q, rsp0Rdata_d;
    logic [DW-1:0] rsp1Rdata_q, rsp1Rdata_d;

    logic grant0, grant1;
    logic selWe;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic [DATA_WIDTH_BYTES-1:0] selBe;
    logic [DW-1:0] selWdata;

`ifdef MEM_ARB_RR_EN
    logic rrPref_q, rrPref_d;

    // Grant only in IDLE; on a tie the pointer picks the port not granted last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst_i && state_q == IDLE) begin
            if (req0_valid_i && req1_valid_i) begin
                grant0 = ~rrPref_q;
                grant1 = rrPref_q;
            end else begin
                grant0 = req0_valid_i;
                grant1 = req1_valid_i;
            end
        end
    end

    // After any accept, the pointer prefers the other port on the next tie.
    always_comb begin
        rrPref_d = rrPref_q;
        if (grant0) begin
            rrPref_d = 1'b1;
        end else if (grant1) begin
            rrPref_d = 1'b0;
        end
    end
`else
    // Grant only in IDLE; load/store always beats fetch, fetch may starve.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst_i && state_q == IDLE) begin
            grant1 = req1_valid_i;
            grant0 = req0_valid_i && !req1_valid_i;
        end
    end
`endif

    // Select the winning port's payload for capture on the accepting edge.
    always_comb begin
        selWe    = grant1 ? req1_we_i    : req0_we_i;
        selAddr  = grant1 ? req1_addr_i  : req0_addr_i;
        selBe    = grant1 ? req1_be_i    : req0_be_i;
        selWdata = grant1 ? req1_wdata_i : req0_wdata_i;
    end

    // Sequencer: idle memory drive and no response unless a step below says so.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        we_d          = we_q;
        cnt_d         = cnt_q;
        memWenableL_d = '1;
        memAddr_d     = '0;
        memW_d        = '0;
        rsp0Valid_d   = 1'b0;
        rsp1Valid_d   = 1'b0;
        rsp0Rdata_d   = rsp0Rdata_q;
        rsp1Rdata_d   = rsp1Rdata_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_d   = ACCESS;
                    owner_d   = grant1;
                    we_d      = selWe;
                    cnt_d     = '0;
                    memAddr_d = selAddr;
                    if (selWe) begin
                        memW_d        = selWdata;
                        memWenableL_d = ~selBe;
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        rsp1Valid_d = 1'b1;
                        rsp1Rdata_d = '0;
                    end else begin
                        rsp0Valid_d = 1'b1;
                        rsp0Rdata_d = '0;
                    end
                end else if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        rsp1Valid_d = 1'b1;
                        rsp1Rdata_d = mem_r_i;
                    end else begin
                        rsp0Valid_d = 1'b1;
                        rsp0Rdata_d = mem_r_i;
                    end
                end else begin
                    memAddr_d = memAddr_q;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction without a response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            we_q          <= 1'b0;
            cnt_q         <= '0;
            memWenableL_q <= '1;
            memAddr_q     <= '0;
            memW_q        <= '0;
            rsp0Valid_q   <= 1'b0;
            rsp1Valid_q   <= 1'b0;
            rsp0Rdata_q   <= '0;
            rsp1Rdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
            rrPref_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            we_q          <= we_d;
            cnt_q         <= cnt_d;
            memWenableL_q <= memWenableL_d;
            memAddr_q     <= memAddr_d;
            memW_q        <= memW_d;
            rsp0Valid_q   <= rsp0Valid_d;
            rsp1Valid_q   <= rsp1Valid_d;
            rsp0Rdata_q   <= rsp0Rdata_d;
            rsp1Rdata_q   <= rsp1Rdata_d;
`ifdef MEM_ARB_RR_EN
            rrPref_q      <= rrPref_d;
`endif
        end
    end

    assign req0_ready_o   = grant0;
    assign req1_ready_o   = grant1;
    assign rsp0_valid_o   = rsp0Valid_q;
    assign rsp1_valid_o   = rsp1Valid_q;
    assign rsp0_rdata_o   = rsp0Rdata_q;
    assign rsp1_rdata_o   = rsp1Rdata_q;
    assign mem_wenableL_o = memWenableL_q;
    assign mem_addr_o     = memAddr_q;
    assign mem_w_o        = memW_q;

endmodule
